// File: rtl/aes_pkg.sv
// Shared AES datapath definitions: widths, round-stage FSM states and
// the column-slice helper used to address one 32-bit column of the state.
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_COL_W   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MIX  = 2'd1,
    HOLD = 2'd2
  } fsm_state_e;

  // Column c occupies [127-32c -: 32]; this returns the LSB of that slice.
  function automatic int col_lsb(input logic [1:0] col);
    return AES_STATE_W - AES_COL_W * (int'(col) + 1);
  endfunction

endpackage

// File: rtl/mul_32bit.sv
// AES MixColumns on a single 32-bit column over GF(2^8), poly 0x11B.
// Row-0 byte sits in the MSB of the column.
module mul_32bit
  import aes_pkg::*;
(
  input  logic [AES_COL_W-1:0] data_in,
  output logic [AES_COL_W-1:0] data_out
);

  // Multiply by x (i.e. by 2) with reduction by the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] a0, a1, a2, a3;

  assign a0 = data_in[31:24];
  assign a1 = data_in[23:16];
  assign a2 = data_in[15:8];
  assign a3 = data_in[7:0];

  // Circulant matrix [2 3 1 1] applied row by row; 3*a is xtime(a)^a.
  always_comb begin
    data_out = '0;
    data_out[31:24] = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
    data_out[23:16] = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
    data_out[15:8]  = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
    data_out[7:0]   = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
  end

endmodule

// File: rtl/shift_rows_128.sv
// AES ShiftRows: row r rotated left by r byte positions across columns.
// Output byte (r,c) takes input byte (r,(c+r) mod 4). Pure wiring.
module shift_rows_128
  import aes_pkg::*;
(
  input  logic [AES_STATE_W-1:0] data_in,
  output logic [AES_STATE_W-1:0] data_out
);

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign data_out[127 - 32*c - 8*r -: 8] =
        data_in[127 - 32*((c + r) % 4) - 8*r -: 8];
    end
  end

endmodule

// File: rtl/aes_shiftrows_mixcol_seq.sv
// Column-serial ShiftRows + MixColumns round stage. ShiftRows is applied
// on capture, then one shared column mixer rewrites the four columns in
// place over four cycles. Final-round blocks skip straight to HOLD.
module aes_shiftrows_mixcol_seq
  import aes_pkg::*;
#(
  parameter int COLS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_state,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_state,
  output logic                   out_last
);

  localparam logic [1:0] LAST_COL = 2'(COLS - 1);

  fsm_state_e             state_q, state_d;
  logic [AES_STATE_W-1:0] st_q;
  logic                   last_q;
  logic [1:0]             col_q;
  logic [AES_STATE_W-1:0] shifted;
  logic [AES_COL_W-1:0]   mix_in, mix_out;

  shift_rows_128 u_shift_rows (
    .data_in  (in_state),
    .data_out (shifted)
  );

  assign mix_in = st_q[col_lsb(col_q) +: AES_COL_W];

  mul_32bit u_mul (
    .data_in  (mix_in),
    .data_out (mix_out)
  );

  // State register plus datapath: capture in IDLE, write back one column per MIX cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      st_q    <= '0;
      last_q  <= 1'b0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            st_q   <= shifted;
            last_q <= in_last;
            col_q  <= '0;
          end
        end
        MIX: begin
          st_q[col_lsb(col_q) +: AES_COL_W] <= mix_out;
          col_q <= col_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Next-state decode; handshake outputs depend only on the registered state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = in_last ? HOLD : MIX;
      MIX:  if (col_q == LAST_COL) state_d = HOLD;
      HOLD: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == HOLD);
  assign out_state = out_valid ? st_q : '0;
  assign out_last  = out_valid & last_q;

endmodule
